// File: rtl/ws_tdm_gen.sv
// rtl/ws_tdm_gen.sv - TDM word-select / frame-sync generator with per-slot FIFO strobes
module ws_tdm_gen #(
    parameter int CH_MAX     = 8,
    parameter int SLOT_W_MAX = 32,
    localparam int CW = $clog2(CH_MAX),
    localparam int BW = $clog2(SLOT_W_MAX)
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [1:0]        fmt,
    input  logic [CW-1:0]     num_ch_m1,
    input  logic [BW-1:0]     slot_bits_m1,
    input  logic [CH_MAX-1:0] slot_mask,
    input  logic              tx_empty,
    input  logic              rx_full,
    output logic              ws,
    output logic [CW-1:0]     ch_idx,
    output logic [BW-1:0]     bit_idx,
    output logic              frame_start,
    output logic              tx_ren,
    output logic              rx_wen,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0]    FMT_I2S  = 2'd0;
    localparam logic [1:0]    FMT_LJ   = 2'd1;
    localparam logic [1:0]    FMT_DSPA = 2'd2;
    localparam logic [1:0]    FMT_DSPB = 2'd3;
    localparam logic [BW-1:0] SB_MIN   = BW'(7);
    localparam logic [CW:0]   ONE_W    = {{CW{1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [1:0]          fmt_q, fmt_d;
    logic [CW-1:0]       nch_q, nch_d;
    logic [BW-1:0]       sb_q, sb_d;
    logic                mode_q, mode_d;
    logic [CH_MAX-1:0]   mask_q, mask_d;
    logic                cont_q, cont_d;
    logic                ws_q, ws_d;
    logic                fs_q, fs_d;
    logic                tx_q, tx_d;
    logic                rx_q, rx_d;

    logic                data_ok;
    logic [CW-1:0]       cfg_nch;
    logic [BW-1:0]       cfg_sb;
    logic                load;
    logic                frame_last_d;

    // Level of ws for a given frame position. cont tells whether another
    // frame follows, which only matters on the frame's last bit.
    function automatic logic ws_calc(
        input logic [1:0]    f,
        input logic [CW-1:0] n,
        input logic [BW-1:0] sb,
        input logic [CW-1:0] c,
        input logic [BW-1:0] b,
        input logic          cont
    );
        logic [CW:0] half;
        logic [CW:0] c_w;
        logic [CW:0] c_nxt;
        logic        last_bit;
        logic        last_slot;
        logic        r;
        half      = ({1'b0, n} + ONE_W) >> 1;
        c_w       = {1'b0, c};
        c_nxt     = c_w + ONE_W;
        last_bit  = (b == sb);
        last_slot = (c == n);
        r         = 1'b0;
        case (f)
            FMT_LJ:   r = (c_w < half);
            FMT_DSPB: r = (c == '0) && (b == '0);
            FMT_DSPA: r = last_bit && last_slot && cont;
            default: begin
                // I2S runs one bit ahead: the last bit of a slot already
                // carries the following slot's level.
                if (last_bit) begin
                    r = last_slot ? !cont : (c_nxt >= half);
                end else begin
                    r = (c_w >= half);
                end
            end
        endcase
        return r;
    endfunction

    assign data_ok = en & (mode ? !rx_full : !tx_empty);

    // Clamp the live configuration to the supported minimums before shadowing.
    always_comb begin
        cfg_sb  = (slot_bits_m1 < SB_MIN) ? SB_MIN : slot_bits_m1;
        cfg_nch = num_ch_m1;
        if (((fmt == FMT_I2S) || (fmt == FMT_LJ)) && (num_ch_m1 == '0)) begin
            cfg_nch = CW'(1);
        end
    end

    // Next-state, counter, shadow and registered-output logic.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        bit_d   = bit_q;
        fmt_d   = fmt_q;
        nch_d   = nch_q;
        sb_d    = sb_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        ws_d    = ws_q;
        fs_d    = 1'b0;
        tx_d    = 1'b0;
        rx_d    = 1'b0;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ch_d  = '0;
                bit_d = '0;
                if (data_ok) begin
                    load    = 1'b1;
                    state_d = ((fmt == FMT_I2S) || (fmt == FMT_DSPA)) ? ST_LEAD : ST_RUN;
                end
            end
            ST_LEAD: begin
                ch_d    = '0;
                bit_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (bit_q == sb_q) begin
                    bit_d = '0;
                    if (ch_q == nch_q) begin
                        ch_d = '0;
                        if (cont_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ch_d    = '0;
                bit_d   = '0;
            end
        endcase

        if (load) begin
            fmt_d  = fmt;
            nch_d  = cfg_nch;
            sb_d   = cfg_sb;
            mode_d = mode;
            mask_d = slot_mask;
        end

        // The continue/stop decision is taken as the frame's last bit begins,
        // so ws on that bit and the wrap on the following edge agree.
        frame_last_d = (state_d == ST_RUN) && (bit_d == sb_d) && (ch_d == nch_d);
        if (frame_last_d) begin
            cont_d = data_ok;
        end

        case (state_d)
            ST_LEAD: ws_d = (fmt_d == FMT_DSPA);
            ST_RUN:  ws_d = ws_calc(fmt_d, nch_d, sb_d, ch_d, bit_d, cont_d);
            default: ws_d = (fmt == FMT_I2S);
        endcase

        if (state_d == ST_RUN) begin
            fs_d = (ch_d == '0) && (bit_d == '0);
            tx_d = (bit_d == '0) && mask_d[ch_d] && !mode_d;
            rx_d = (bit_d == '0) && mask_d[ch_d] && mode_d;
        end
    end

    // State, counters, shadows and outputs advance on the falling sclk edge.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
            bit_q   <= '0;
            fmt_q   <= '0;
            nch_q   <= '0;
            sb_q    <= '0;
            mode_q  <= 1'b0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            ws_q    <= 1'b0;
            fs_q    <= 1'b0;
            tx_q    <= 1'b0;
            rx_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            bit_q   <= bit_d;
            fmt_q   <= fmt_d;
            nch_q   <= nch_d;
            sb_q    <= sb_d;
            mode_q  <= mode_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            ws_q    <= ws_d;
            fs_q    <= fs_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
        end
    end

    assign ws          = ws_q;
    assign ch_idx      = ch_q;
    assign bit_idx     = bit_q;
    assign frame_start = fs_q;
    assign tx_ren      = tx_q;
    assign rx_wen      = rx_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ws_tdm_gen.sv
// tb/tb_ws_tdm_gen.sv - randomized and directed bench for ws_tdm_gen against a frame-position model
module tb_ws_tdm_gen;

    logic       sclk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic [1:0] fmt;
    logic [2:0] num_ch_m1;
    logic [4:0] slot_bits_m1;
    logic [7:0] slot_mask;
    logic       tx_empty;
    logic       rx_full;
    logic       ws;
    logic [2:0] ch_idx;
    logic [4:0] bit_idx;
    logic       frame_start;
    logic       tx_ren;
    logic       rx_wen;
    logic       busy;

    int checks = 0;
    int errors = 0;

    ws_tdm_gen #(.CH_MAX(8), .SLOT_W_MAX(32)) dut (
        .sclk         (sclk),
        .rst          (rst),
        .en           (en),
        .mode         (mode),
        .fmt          (fmt),
        .num_ch_m1    (num_ch_m1),
        .slot_bits_m1 (slot_bits_m1),
        .slot_mask    (slot_mask),
        .tx_empty     (tx_empty),
        .rx_full      (rx_full),
        .ws           (ws),
        .ch_idx       (ch_idx),
        .bit_idx      (bit_idx),
        .frame_start  (frame_start),
        .tx_ren       (tx_ren),
        .rx_wen       (rx_wen),
        .busy         (busy)
    );

    always #5 sclk = ~sclk;

    // Reference model: phase 0 idle, 1 lead, 2 run; pos = bit position in frame.
    int         m_phase;
    int         m_pos;
    int         m_w;
    int         m_n;
    int         m_f;
    logic [1:0] m_fmt;
    logic       m_mode;
    logic [7:0] m_mask;
    logic       m_cont;
    logic       m_idle_ws;

    function automatic logic dok();
        return en && (mode ? !rx_full : !tx_empty);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_w = 8; m_n = 2; m_f = 16;
        m_fmt = 2'd0; m_mode = 1'b0; m_mask = 8'h00; m_cont = 1'b0; m_idle_ws = 1'b0;
    endtask

    task automatic model_latch();
        m_fmt  = fmt;
        m_mode = mode;
        m_mask = slot_mask;
        m_w    = (int'(slot_bits_m1) + 1 < 8) ? 8 : int'(slot_bits_m1) + 1;
        m_n    = int'(num_ch_m1) + 1;
        if (fmt <= 2'd1 && m_n == 1) m_n = 2;
        m_f    = m_w * m_n;
    endtask

    task automatic model_step();
        logic ok;
        ok = dok();
        case (m_phase)
            0: if (ok) begin
                   model_latch();
                   m_phase = (fmt == 2'd0 || fmt == 2'd2) ? 1 : 2;
                   m_pos = 0;
               end
            1: begin m_phase = 2; m_pos = 0; end
            default: begin
                if (m_pos == m_f - 1) begin
                    if (m_cont) begin m_pos = 0; model_latch(); end
                    else begin m_phase = 0; m_pos = 0; end
                end else begin
                    m_pos++;
                end
            end
        endcase
        if (m_phase == 0) m_idle_ws = (fmt == 2'd0);
        if (m_phase == 2 && m_pos == m_f - 1) m_cont = ok;
    endtask

    function automatic logic [12:0] expv();
        logic e_ws, e_fs, e_tx, e_rx, e_busy;
        int c, b, half, nxt;
        c = 0; b = 0; e_ws = 1'b0; e_fs = 1'b0; e_tx = 1'b0; e_rx = 1'b0;
        e_busy = (m_phase != 0);
        if (m_phase == 0) begin
            e_ws = m_idle_ws;
        end else if (m_phase == 1) begin
            e_ws = (m_fmt == 2'd2);
        end else begin
            c = m_pos / m_w;
            b = m_pos % m_w;
            half = m_n / 2;
            case (m_fmt)
                2'd1: e_ws = (c < half);
                2'd3: e_ws = (m_pos == 0);
                2'd2: e_ws = (m_pos == m_f - 1) && m_cont;
                default: begin
                    nxt = m_pos + 1;
                    e_ws = (nxt == m_f) ? !m_cont : ((nxt / m_w) >= half);
                end
            endcase
            e_fs = (m_pos == 0);
            e_tx = (b == 0) && m_mask[c] && !m_mode;
            e_rx = (b == 0) && m_mask[c] && m_mode;
        end
        return {e_ws, 3'(c), 5'(b), e_fs, e_tx, e_rx, e_busy};
    endfunction

    function automatic logic [12:0] obs();
        return {ws, ch_idx, bit_idx, frame_start, tx_ren, rx_wen, busy};
    endfunction

    // One falling edge (DUT and model update), then sample on the rising edge.
    task automatic tick();
        @(negedge sclk);
        if (rst) model_reset(); else model_step();
        @(posedge sclk);
    endtask

    task automatic drain();
        int n;
        en = 1'b0;
        n = 0;
        while (m_phase != 0 && n < 700) begin
            tick();
            n++;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL drain: got %h expected %h", obs(), expv()); end
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 1'b0; fmt = 2'd1; num_ch_m1 = 3'd1;
        slot_bits_m1 = 5'd7; slot_mask = 8'hFF; tx_empty = 1'b1; rx_full = 1'b0;
        tick();
        checks++;
        if (obs() !== 13'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", obs()); end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== expv()) begin errors++; $display("FAIL reset_idle_lj: got %h expected %h", obs(), expv()); end
        checks++;
        if (ws !== 1'b0) begin errors++; $display("FAIL reset_idle_ws: got %b expected 0", ws); end
    endtask

    task automatic test_i2s_basic();
        int ntx = 0, first_tx = -1, second_tx = -1;
        fmt = 2'd0; num_ch_m1 = 3'd1; slot_bits_m1 = 5'd15; mode = 1'b0;
        tx_empty = 1'b0; slot_mask = 8'hFF; en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) en = 1'b0;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL i2s_cycle%0d: got %h expected %h", i, obs(), expv()); end
            if (tx_ren === 1'b1) begin
                ntx++;
                if (ntx == 1) first_tx = i; else if (ntx == 2) second_tx = i;
            end
        end
        checks++;
        if (first_tx != 1 || second_tx != 17 || ntx != 2) begin
            errors++; $display("FAIL i2s_tx_times: got %0d,%0d n=%0d expected 1,17 n=2", first_tx, second_tx, ntx);
        end
        checks++;
        if ({ws, busy} !== 2'b10) begin errors++; $display("FAIL i2s_idle: ws,busy got %b expected 10", {ws, busy}); end
    endtask

    task automatic test_dsp_b_tdm();
        int ntx = 0, nfs = 0, nws = 0, nidle = 0;
        fmt = 2'd3; num_ch_m1 = 3'd7; slot_bits_m1 = 5'd31; slot_mask = 8'b1010_0101;
        mode = 1'b0; tx_empty = 1'b0; en = 1'b1;
        for (int i = 0; i < 600; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL dspb_cycle%0d: got %h expected %h", i, obs(), expv()); end
            if (i < 256 && tx_ren === 1'b1) ntx++;
            if (frame_start === 1'b1) nfs++;
            if (ws === 1'b1) nws++;
            if (busy !== 1'b1) nidle++;
        end
        checks++;
        if (ntx != 4) begin errors++; $display("FAIL dspb_tx_count: got %0d expected 4", ntx); end
        checks++;
        if (nfs != 3 || nws != 3) begin errors++; $display("FAIL dspb_frames: fs %0d ws %0d expected 3 3", nfs, nws); end
        checks++;
        if (nidle != 0) begin errors++; $display("FAIL dspb_gap: idle cycles %0d expected 0", nidle); end
        drain();
    endtask

    task automatic test_lj_rx_backpressure();
        int nrx = 0, idle_at = -1, resume_at = -1;
        fmt = 2'd1; mode = 1'b1; num_ch_m1 = 3'd1; slot_bits_m1 = 5'd7; slot_mask = 8'hFF;
        tx_empty = 1'b1; rx_full = 1'b0; en = 1'b1;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (i == 20) rx_full = 1'b1;
            if (i == 45) rx_full = 1'b0;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL lj_cycle%0d: got %h expected %h", i, obs(), expv()); end
            if (rx_wen === 1'b1) nrx++;
            if (busy === 1'b0 && idle_at < 0) idle_at = i;
            if (busy === 1'b1 && idle_at >= 0 && resume_at < 0) resume_at = i;
        end
        checks++;
        if (idle_at != 32 || resume_at != 46) begin
            errors++; $display("FAIL lj_stop_resume: got %0d,%0d expected 32,46", idle_at, resume_at);
        end
        checks++;
        if (nrx != 7) begin errors++; $display("FAIL lj_rx_count: got %0d expected 7", nrx); end
        drain();
        mode = 1'b0;
    endtask

    task automatic test_dsp_a_reconfig();
        int fsi[$];
        int nws = 0;
        fmt = 2'd2; num_ch_m1 = 3'd3; slot_bits_m1 = 5'd7; slot_mask = 8'hFF;
        mode = 1'b0; tx_empty = 1'b0; en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (i == 10) num_ch_m1 = 3'd5;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL dspa_cycle%0d: got %h expected %h", i, obs(), expv()); end
            if (frame_start === 1'b1) fsi.push_back(i);
            if (ws === 1'b1) nws++;
        end
        checks++;
        if (fsi.size() != 3 || fsi[0] != 1 || fsi[1] != 33 || fsi[2] != 81) begin
            errors++; $display("FAIL dspa_frame_len: got %0d starts, expected starts at 1,33,81", fsi.size());
        end
        checks++;
        if (nws != 3) begin errors++; $display("FAIL dspa_ws_count: got %0d expected 3", nws); end
        drain();
    endtask

    task automatic test_clamp();
        int max_b = 0, max_c = 0;
        fmt = 2'd1; num_ch_m1 = 3'd0; slot_bits_m1 = 5'd3; slot_mask = 8'hFF;
        mode = 1'b0; tx_empty = 1'b0; en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL clamp_cycle%0d: got %h expected %h", i, obs(), expv()); end
            if (int'(bit_idx) > max_b) max_b = int'(bit_idx);
            if (int'(ch_idx) > max_c) max_c = int'(ch_idx);
        end
        checks++;
        if (max_b != 7 || max_c != 1) begin errors++; $display("FAIL clamp_range: bit %0d ch %0d expected 7 1", max_b, max_c); end
        drain();
    endtask

    task automatic test_reset_midframe();
        int n = 0, ntx = 0;
        fmt = 2'd0; num_ch_m1 = 3'd3; slot_bits_m1 = 5'd15; slot_mask = 8'hFF;
        mode = 1'b0; tx_empty = 1'b0; en = 1'b1;
        while (!(m_phase == 2 && m_pos == 2 * 16 + 10) && n < 200) begin
            tick();
            n++;
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL rstmid_run%0d: got %h expected %h", n, obs(), expv()); end
        end
        checks++;
        if (ch_idx !== 3'd2 || bit_idx !== 5'd10) begin
            errors++; $display("FAIL rstmid_reach: ch %0d bit %0d expected 2 10", ch_idx, bit_idx);
        end
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs() !== 13'h0) begin errors++; $display("FAIL rstmid_async: got %h expected 0", obs()); end
        #1 rst = 1'b0;
        en = 1'b0;
        tick();
        checks++;
        if (ws !== 1'b1 || obs() !== expv()) begin errors++; $display("FAIL rstmid_idle_ws: got %h expected %h", obs(), expv()); end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_ren !== 1'b0) ntx++;
        end
        checks++;
        if (ntx != 0) begin errors++; $display("FAIL rstmid_no_strobe: got %0d strobes expected 0", ntx); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                fmt = 2'($urandom_range(0, 3));
                num_ch_m1 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 5))
                    0: slot_bits_m1 = 5'd3;
                    1: slot_bits_m1 = 5'd7;
                    2: slot_bits_m1 = 5'd8;
                    3: slot_bits_m1 = 5'd15;
                    4: slot_bits_m1 = 5'd31;
                    default: slot_bits_m1 = 5'($urandom_range(0, 31));
                endcase
                mode = 1'($urandom_range(0, 1));
                slot_mask = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) tx_empty = ~tx_empty;
            if ($urandom_range(0, 39) == 0) rx_full = ~rx_full;
            tick();
            checks++;
            if (obs() !== expv()) begin errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, obs(), expv()); end
            checks++;
            if ((tx_ren & rx_wen) !== 1'b0) begin errors++; $display("FAIL random_exclusive: tx %b rx %b expected not both", tx_ren, rx_wen); end
        end
        drain();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_i2s_basic();
        test_dsp_b_tdm();
        test_lj_rx_backpressure();
        test_dsp_a_reconfig();
        test_clamp();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws_tdm_gen.md
Name: ws_tdm_gen

Overview:
- Parametrised successor of the two-channel word-select generator.
- Generates word-select / frame-sync for a multi-slot TDM serial audio frame, with configurable slot width, slot count and framing format (I2S, left-justified, DSP-A, DSP-B).
- Provides per-slot FIFO strobes gated by a slot mask, plus channel and bit position outputs.
- Sits between the control register block and the Tx/Rx shift paths/FIFOs in master mode.

Parameters:
- CH_MAX, 8, maximum slots per frame (power of 2, ≥2).
- SLOT_W_MAX, 32, maximum bits per slot (power of 2, ≥8).

Ports:
- sclk  in  1  serial bit clock; all state updates on falling edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  transfer enable (OP.tran_en equivalent).
- mode  in  1  0 = master transmit (MT), 1 = master receive (MR).
- fmt  in  2  0 = I2S, 1 = LJ, 2 = DSP_A, 3 = DSP_B.
- num_ch_m1  in  clog2(CH_MAX)  slots per frame minus 1.
- slot_bits_m1  in  clog2(SLOT_W_MAX)  bits per slot minus 1.
- slot_mask  in  CH_MAX  bit i = 1 enables FIFO strobe for slot i.
- tx_empty  in  1  Tx FIFO empty.
- rx_full  in  1  Rx FIFO full.
- ws  out  1  word-select / frame-sync.
- ch_idx  out  clog2(CH_MAX)  current slot number.
- bit_idx  out  clog2(SLOT_W_MAX)  bit position in slot, 0 = MSB.
- frame_start  out  1  high for the first bit of slot 0.
- tx_ren  out  1  one-sclk Tx FIFO read strobe.
- rx_wen  out  1  one-sclk Rx FIFO write strobe.
- busy  out  1  high in LEAD or RUN.

Behaviour:
- Reset values: all outputs and counters 0; state = IDLE. Reset is effective immediately, including mid-frame, with no frame completion.
- data_ok = en & (mode ? !rx_full : !tx_empty).
- Config shadowing: fmt, num_ch_m1, slot_bits_m1, mode and slot_mask are latched into shadow registers on every IDLE→LEAD/RUN transition and at each frame wrap. Mid-frame changes are ignored.
- Clamping: slot_bits_m1 < 7 is clamped to 7. For I2S/LJ, num_ch_m1 = 0 is clamped to 1.
- States:
  - IDLE: counters held at 0. ws = 1 if fmt = I2S, else 0. If data_ok: go to LEAD when fmt ∈ {I2S, DSP_A}, otherwise go to RUN.
  - LEAD: exactly one sclk. ws = first-slot level (I2S 0, DSP_A 1). Counters stay 0. Always go to RUN.
  - RUN: bit_idx increments each sclk.
    - At bit_idx = slot_bits_m1, bit_idx wraps to 0 and ch_idx increments.
    - At ch_idx = num_ch_m1 with bit wrap (frame end): if data_ok, ch_idx → 0 and stay in RUN (no LEAD between frames); else go to IDLE.
    - data_ok is sampled only at frame end; en deasserted mid-frame completes the current frame.
- ws in RUN: half = (num_ch_m1 + 1) / 2.
  - LJ: ws = 1 while ch_idx < half, 0 otherwise.
  - I2S: ws = 0 for slots < half, 1 otherwise, leading the slot boundary by one bit. ws shows the next slot's level on the last bit of the previous slot. On the last bit of the frame, ws = 0 if continuing and 1 if returning to IDLE.
  - DSP_B: ws = 1 only on bit 0 of slot 0.
  - DSP_A: ws = 1 only on the last bit of the frame when continuing; otherwise 0.
- frame_start = 1 when RUN & ch_idx = 0 & bit_idx = 0.
- tx_ren/rx_wen:
  - Registered one-sclk pulse in RUN at bit_idx = 0 when slot_mask[ch_idx] = 1.
  - tx_ren when mode = MT, rx_wen when mode = MR; the two are never both high.
  - Unmasked slots are still clocked, but produce no strobe.
- Latency: first RUN bit follows one sclk after the enabling edge, or two with LEAD.

Test Plan:
- I2S, num_ch_m1 = 1, slot_bits_m1 = 15, mode MT, tx_empty = 0, en pulse → one LEAD cycle with ws = 0, then 16 bits ws = 0 with ws = 1 on bit 15 of slot 0, then 16 bits ws = 1. tx_ren pulses at sclk 1 and 17 after LEAD. Returns to IDLE with ws = 1.
- DSP_B TDM, num_ch_m1 = 7, slot_bits_m1 = 31, slot_mask = 8'b1010_0101, en held → 256-bit frames; ws = 1 only at frame_start; tx_ren only in slots 0, 2, 5, 7. Frames are continuous with no idle gap.
- LJ, mode MR, rx_full rises mid-frame → current frame completes; enters IDLE at frame end; no rx_wen issued after. Resumes at the next boundary after rx_full falls.
- DSP_A, en held, num_ch_m1 changed 3 → 5 mid-frame → current frame keeps 4 slots, next frame has 6. ws pulses on the last bit of each frame.
- slot_bits_m1 = 3 → behaves as 8-bit slots; bit_idx wraps at 7.
- Assert rst at bit 10 of slot 2 → all outputs 0 immediately. After release: I2S idle ws = 1 on first falling edge; no strobes until a new frame starts.
